// File: rtl/pred_decoder.sv
// pred_decoder: picks the index of the largest element of a vector of
// IEEE-754 single-precision logits. A start captures the whole vector, then
// one element is compared per cycle. The winning index and a one-hot float
// vector (1.0 at the winner, 0.0 elsewhere) are registered when the scan ends.
//
// Ports
//   clk          clock; all state changes on its rising edge
//   rst          asynchronous active-high reset
//   start        decode request; sampled only in IDLE
//   pred         logits; element k in bits [k*bw +: bw]
//   busy         high in SCAN and DONE
//   done         one-cycle pulse while in DONE; result valid
//   char_idx     index of the winning element
//   char_onehot  one-hot float vector of the winner
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SCAN  | comparing captured element cnt against the running best
// DONE  | result registered, done high for this single cycle
module pred_decoder #(
   parameter int enc = 27,
   parameter int bw  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [bw*enc-1:0] pred,
   output logic              busy,
   output logic              done,
   output logic [4:0]        char_idx,
   output logic [bw*enc-1:0] char_onehot
);

   localparam logic [1:0]    ST_IDLE  = 2'd0;
   localparam logic [1:0]    ST_SCAN  = 2'd1;
   localparam logic [1:0]    ST_DONE  = 2'd2;
   localparam logic [4:0]    LAST_IDX = 5'(enc - 1);
   localparam logic [bw-1:0] ONE_F    = bw'(32'h3F800000);

   logic [1:0]        state_q, state_d;
   logic [bw*enc-1:0] cap_q, cap_d;
   logic [bw-1:0]     best_q, best_d;
   logic [4:0]        best_idx_q, best_idx_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [4:0]        char_idx_q, char_idx_d;
   logic [bw*enc-1:0] char_onehot_q, char_onehot_d;

   logic [bw-1:0]     cand;
   logic              take;
   logic [4:0]        scan_idx;
   logic [bw*enc-1:0] onehot_next;

   function automatic logic is_nan(input logic [bw-1:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   // Strict a > b. NaN loses to everything (a NaN best is always replaced),
   // +0 and -0 compare equal, otherwise plain sign-magnitude ordering, which
   // also orders infinities correctly.
   function automatic logic f_gt(input logic [bw-1:0] a, input logic [bw-1:0] b);
      logic [30:0] ma;
      logic [30:0] mb;
      ma = a[30:0];
      mb = b[30:0];
      if (is_nan(a)) return 1'b0;
      if (is_nan(b)) return 1'b1;
      if ((ma == 31'd0) && (mb == 31'd0)) return 1'b0;
      if (a[31] != b[31]) return b[31];
      if (!a[31]) return ma > mb;
      return ma < mb;
   endfunction

   always_comb begin
      cand     = cap_q[int'(cnt_q)*bw +: bw];
      take     = f_gt(cand, best_q);
      scan_idx = take ? cnt_q : best_idx_q;
   end

   always_comb begin
      onehot_next = '0;
      for (int k = 0; k < enc; k++) begin
         if (5'(k) == scan_idx) onehot_next[k*bw +: bw] = ONE_F;
      end
   end

   always_comb begin
      state_d       = state_q;
      cap_d         = cap_q;
      best_d        = best_q;
      best_idx_d    = best_idx_q;
      cnt_d         = cnt_q;
      char_idx_d    = char_idx_q;
      char_onehot_d = char_onehot_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cap_d      = pred;
               best_d     = pred[bw-1:0];
               best_idx_d = 5'd0;
               cnt_d      = 5'd1;
               state_d    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (take) begin
               best_d     = cand;
               best_idx_d = cnt_q;
            end
            // The result is registered on the same edge that leaves SCAN so it
            // includes the final element's compare.
            if (cnt_q == LAST_IDX) begin
               state_d       = ST_DONE;
               cnt_d         = 5'd0;
               char_idx_d    = scan_idx;
               char_onehot_d = onehot_next;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cap_q         <= '0;
         best_q        <= '0;
         best_idx_q    <= '0;
         cnt_q         <= '0;
         char_idx_q    <= '0;
         char_onehot_q <= '0;
      end else begin
         state_q       <= state_d;
         cap_q         <= cap_d;
         best_q        <= best_d;
         best_idx_q    <= best_idx_d;
         cnt_q         <= cnt_d;
         char_idx_q    <= char_idx_d;
         char_onehot_q <= char_onehot_d;
      end
   end

   // Decoded straight from the state so reset clears them without waiting a clock.
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign char_idx    = char_idx_q;
   assign char_onehot = char_onehot_q;

endmodule
